// File: rtl/dep_pkg.sv
// Shared opcode, instruction-layout and FSM-state definitions for the
// dependency-checker program server.
package dep_pkg;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_MUL = 4'd2;
  localparam logic [3:0] OP_DIV = 4'd3;
  localparam logic [3:0] OP_END = 4'd4;

  localparam int NIBBLES_PER_INSTR = 4;

  localparam int OPC  = 0;
  localparam int DST  = 1;
  localparam int SRC1 = 2;
  localparam int SRC2 = 3;

  typedef enum logic [1:0] {
    LOAD,
    SERVE,
    DONE
  } state_t;

  // Instructions are 4 nibbles wide, so the slot is the low two address bits.
  function automatic logic is_opcode_slot(input logic [1:0] slot);
    return slot == 2'(OPC);
  endfunction

endpackage

// File: rtl/dep_regfile.sv
// Small register file: synchronous init to BASE+i, one write port and a
// registered read port that returns same-cycle write data (write-first).
module dep_regfile #(
  parameter int REG_AW        = 3,
  parameter int DATA_W        = 8,
  parameter int REG_INIT_BASE = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rd_req_i,
  input  logic [REG_AW-1:0] rd_addr_i,
  input  logic              wr_en_i,
  input  logic [REG_AW-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  output logic              rd_valid_o,
  output logic [DATA_W-1:0] rd_data_o
);

  localparam int NREG = 2 ** REG_AW;

  logic [DATA_W-1:0] regs_q [NREG];
  logic              rd_valid_q;
  logic [DATA_W-1:0] rd_data_q;
  logic [DATA_W-1:0] rd_data_d;

  always_comb begin
    rd_data_d = regs_q[rd_addr_i];
    if (wr_en_i && (wr_addr_i == rd_addr_i)) begin
      rd_data_d = wr_data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= DATA_W'(REG_INIT_BASE + i);
      end
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      if (wr_en_i) begin
        regs_q[wr_addr_i] <= wr_data_i;
      end
      rd_valid_q <= rd_req_i;
      if (rd_req_i) begin
        rd_data_q <= rd_data_d;
      end
    end
  end

  assign rd_valid_o = rd_valid_q;
  assign rd_data_o  = rd_data_q;

endmodule

// File: rtl/dep_program_server.sv
// Program/register responder for the dependency checker: nibble-stream program
// load, 1-cycle fetch and register-read responses, END-opcode tracking.
module dep_program_server
  import dep_pkg::*;
#(
  parameter int ADDR_W        = 6,
  parameter int REG_AW        = 3,
  parameter int DATA_W        = 8,
  parameter int REG_INIT_BASE = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ld_valid_i,
  output logic              ld_ready_o,
  input  logic [3:0]        ld_nibble_i,
  input  logic              ld_last_i,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic              if_valid_o,
  output logic [3:0]        if_data_o,
  input  logic              rf_req_i,
  input  logic [REG_AW-1:0] rf_addr_i,
  output logic              rf_valid_o,
  output logic [DATA_W-1:0] rf_data_o,
  input  logic              wb_valid_i,
  input  logic [REG_AW-1:0] wb_addr_i,
  input  logic [DATA_W-1:0] wb_data_i,
  output logic              busy_load_o,
  output logic              end_seen_o,
  output logic [ADDR_W:0]   prog_len_o
);

  localparam int                DEPTH   = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] PTR_MAX = ADDR_W'(DEPTH - 1);

  state_t            state_q;
  logic              ld_ready_q;
  logic              if_valid_q;
  logic [3:0]        if_data_q;
  logic              end_seen_q;
  logic [ADDR_W:0]   prog_len_q;
  logic [ADDR_W-1:0] ptr_q;

  logic [3:0]        mem [DEPTH];
  logic              load_accept;
  logic              serving;
  logic [3:0]        fetch_nib_d;
  logic              fetch_is_end;

  assign load_accept = rst_n && (state_q == LOAD) && ld_valid_i && ld_ready_q;
  assign serving     = (state_q == SERVE) || (state_q == DONE);

  // Anything past the loaded program reads as END so a runaway PC terminates.
  always_comb begin
    fetch_nib_d = OP_END;
    if ({1'b0, if_addr_i} < prog_len_q) begin
      fetch_nib_d = mem[if_addr_i];
    end
  end

  assign fetch_is_end = (fetch_nib_d == OP_END) && is_opcode_slot(if_addr_i[1:0]);

  // Program memory is deliberately left uncleared by reset.
  always_ff @(posedge clk) begin
    if (load_accept) begin
      mem[ptr_q] <= ld_nibble_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= LOAD;
      ld_ready_q <= 1'b0;
      if_valid_q <= 1'b0;
      if_data_q  <= 4'h0;
      end_seen_q <= 1'b0;
      prog_len_q <= '0;
      ptr_q      <= '0;
    end else begin
      if_valid_q <= 1'b0;
      unique case (state_q)
        LOAD: begin
          ld_ready_q <= 1'b1;
          if (load_accept) begin
            ptr_q <= ptr_q + ADDR_W'(1);
            if (ld_last_i || (ptr_q == PTR_MAX)) begin
              prog_len_q <= {1'b0, ptr_q} + (ADDR_W + 1)'(1);
              ld_ready_q <= 1'b0;
              state_q    <= SERVE;
            end
          end
        end
        SERVE, DONE: begin
          if (if_req_i) begin
            if_valid_q <= 1'b1;
            if_data_q  <= fetch_nib_d;
            if ((state_q == SERVE) && fetch_is_end) begin
              end_seen_q <= 1'b1;
              state_q    <= DONE;
            end
          end
        end
        default: state_q <= LOAD;
      endcase
    end
  end

  dep_regfile #(
    .REG_AW        (REG_AW),
    .DATA_W        (DATA_W),
    .REG_INIT_BASE (REG_INIT_BASE)
  ) u_regfile (
    .clk        (clk),
    .rst_n      (rst_n),
    .rd_req_i   (rf_req_i && serving),
    .rd_addr_i  (rf_addr_i),
    .wr_en_i    (wb_valid_i && serving),
    .wr_addr_i  (wb_addr_i),
    .wr_data_i  (wb_data_i),
    .rd_valid_o (rf_valid_o),
    .rd_data_o  (rf_data_o)
  );

  assign ld_ready_o  = ld_ready_q;
  assign if_valid_o  = if_valid_q;
  assign if_data_o   = if_data_q;
  assign busy_load_o = (state_q == LOAD);
  assign end_seen_o  = end_seen_q;
  assign prog_len_o  = prog_len_q;

endmodule

// File: tb/tb_dep_program_server.sv
// Scenario bench for dep_program_server against a simple array/register model.
module tb_dep_program_server;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ld_valid, ld_last, if_req, rf_req, wb_valid;
  logic [3:0] ld_nibble;
  logic [5:0] if_addr;
  logic [2:0] rf_addr, wb_addr;
  logic [7:0] wb_data;
  logic       ld_ready, if_valid, rf_valid, busy_load, end_seen;
  logic [3:0] if_data;
  logic [7:0] rf_data;
  logic [6:0] prog_len;

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic [3:0] m_mem [64];
  logic [7:0] m_reg [8];
  int         m_len;
  logic       m_end;

  int prog [29] = '{0,5,0,1, 2,6,2,5, 1,5,3,6, 3,6,5,4, 2,2,3,4, 1,6,5,4, 2,6,2,1, 4};

  always #5 clk = ~clk;

  dep_program_server dut (
    .clk(clk), .rst_n(rst_n),
    .ld_valid_i(ld_valid), .ld_ready_o(ld_ready), .ld_nibble_i(ld_nibble), .ld_last_i(ld_last),
    .if_req_i(if_req), .if_addr_i(if_addr), .if_valid_o(if_valid), .if_data_o(if_data),
    .rf_req_i(rf_req), .rf_addr_i(rf_addr), .rf_valid_o(rf_valid), .rf_data_o(rf_data),
    .wb_valid_i(wb_valid), .wb_addr_i(wb_addr), .wb_data_i(wb_data),
    .busy_load_o(busy_load), .end_seen_o(end_seen), .prog_len_o(prog_len)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ld_valid = 0; ld_last = 0; ld_nibble = 0;
    if_req = 0; if_addr = 0; rf_req = 0; rf_addr = 0;
    wb_valid = 0; wb_addr = 0; wb_data = 0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_reg[i] = 8'(2 + i);
    m_len = 0;
    m_end = 0;
  endtask

  task automatic do_reset();
    rst_n = 0;
    step();
    step();
    model_reset();
    rst_n = 1;
    step();
  endtask

  // Fetch one nibble and compare against the model; tracks END in opcode slots.
  task automatic do_fetch(input logic [5:0] a);
    logic [3:0] exp_nib;
    if_req = 1; if_addr = a;
    step();
    if_req = 0;
    exp_nib = (int'(a) < m_len) ? m_mem[a] : 4'h4;
    if (exp_nib == 4'h4 && a % 4 == 0) m_end = 1;
    $display("fetch addr=%0d data=%0h end_seen=%0b", a, if_data, end_seen);
    if (if_valid !== 1'b1) begin errors++; $display("FAIL fetch_valid addr=%0d got=%b want=1", a, if_valid); end
    checks++;
    if (if_data !== exp_nib) begin errors++; $display("FAIL fetch_data addr=%0d got=%0h want=%0h", a, if_data, exp_nib); end
    checks++;
    if (end_seen !== m_end) begin errors++; $display("FAIL fetch_end addr=%0d got=%b want=%b", a, end_seen, m_end); end
    checks++;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 0;
    step();
    step();
    model_reset();
    $display("reset ld_ready=%0b prog_len=%0d", ld_ready, prog_len);
    if (ld_ready !== 1'b0) begin errors++; $display("FAIL reset_ld_ready got=%b want=0", ld_ready); end
    checks++;
    if ({if_valid, rf_valid, end_seen} !== 3'b000) begin
      errors++; $display("FAIL reset_flags got=%b want=000", {if_valid, rf_valid, end_seen});
    end
    checks++;
    if (prog_len !== 7'd0 || busy_load !== 1'b1) begin
      errors++; $display("FAIL reset_len got=%0d/%b want=0/1", prog_len, busy_load);
    end
    checks++;
    rst_n = 1;
    step();
    if (ld_ready !== 1'b1) begin errors++; $display("FAIL ld_ready_rise got=%b want=1", ld_ready); end
    checks++;
  endtask

  task automatic test_load_program();
    for (int i = 0; i < 29; i++) begin
      ld_valid = 1; ld_nibble = 4'(prog[i]); ld_last = (i == 28);
      if (ld_ready !== 1'b1) begin errors++; $display("FAIL load_ready idx=%0d got=%b want=1", i, ld_ready); end
      checks++;
      step();
      m_mem[i] = 4'(prog[i]);
    end
    m_len = 29;
    idle_inputs();
    $display("load done prog_len=%0d ld_ready=%0b busy=%0b", prog_len, ld_ready, busy_load);
    if (prog_len !== 7'd29) begin errors++; $display("FAIL load_len got=%0d want=29", prog_len); end
    checks++;
    if (ld_ready !== 1'b0 || busy_load !== 1'b0) begin
      errors++; $display("FAIL load_exit got=%b/%b want=0/0", ld_ready, busy_load);
    end
    checks++;
  endtask

  task automatic test_fetch();
    do_fetch(6'd7);
    do_fetch(6'd12);
    do_fetch(6'd15);
    if (busy_load !== 1'b0) begin errors++; $display("FAIL src2_end busy got=%b want=0", busy_load); end
    checks++;
  endtask

  task automatic test_end();
    do_fetch(6'd28);
    do_fetch(6'd40);
    do_fetch(6'd1);
  endtask

  task automatic test_regfile();
    rf_req = 1; rf_addr = 3'd5;
    step();
    rf_req = 0;
    $display("rf read R5 data=%0h", rf_data);
    if (rf_valid !== 1'b1 || rf_data !== m_reg[5]) begin
      errors++; $display("FAIL rf_init got=%b/%0h want=1/%0h", rf_valid, rf_data, m_reg[5]);
    end
    checks++;
    rf_req = 1; rf_addr = 3'd5; wb_valid = 1; wb_addr = 3'd5; wb_data = 8'h0A;
    step();
    m_reg[5] = 8'h0A;
    idle_inputs();
    $display("rf bypass R5 data=%0h", rf_data);
    if (rf_valid !== 1'b1 || rf_data !== 8'h0A) begin
      errors++; $display("FAIL rf_bypass got=%b/%0h want=1/0a", rf_valid, rf_data);
    end
    checks++;
    step();
    if (rf_valid !== 1'b0) begin errors++; $display("FAIL rf_valid_drop got=%b want=0", rf_valid); end
    checks++;
  endtask

  // Mixed random fetch/read/write-back traffic, one transaction per cycle.
  task automatic test_back_to_back();
    logic [3:0] exp_nib;
    logic [7:0] exp_rf;
    logic       ireq, rreq, wv;
    for (int n = 0; n < 200; n++) begin
      ireq = 1'($urandom); rreq = 1'($urandom); wv = 1'($urandom);
      if_req = ireq; if_addr = 6'($urandom);
      rf_req = rreq; rf_addr = 3'($urandom);
      wb_valid = wv; wb_addr = 3'($urandom); wb_data = 8'($urandom);
      exp_nib = (int'(if_addr) < m_len) ? m_mem[if_addr] : 4'h4;
      exp_rf = (wv && wb_addr == rf_addr) ? wb_data : m_reg[rf_addr];
      if (ireq && exp_nib == 4'h4 && if_addr % 4 == 0) m_end = 1;
      step();
      if (wv) m_reg[wb_addr] = wb_data;
      $display("b2b %0d if=%0b/%0h rf=%0b/%0h", n, if_valid, if_data, rf_valid, rf_data);
      if (if_valid !== ireq || rf_valid !== rreq) begin
        errors++; $display("FAIL b2b_valid n=%0d got=%b%b want=%b%b", n, if_valid, rf_valid, ireq, rreq);
      end
      checks++;
      if (ireq && if_data !== exp_nib) begin
        errors++; $display("FAIL b2b_if n=%0d got=%0h want=%0h", n, if_data, exp_nib);
      end
      if (ireq) checks++;
      if (rreq && rf_data !== exp_rf) begin
        errors++; $display("FAIL b2b_rf n=%0d got=%0h want=%0h", n, rf_data, exp_rf);
      end
      if (rreq) checks++;
    end
    wb_valid = 1; wb_addr = 3'd3; wb_data = 8'hEE; if_req = 0; rf_req = 0;
    step();
    m_reg[3] = 8'hEE;
    idle_inputs();
  endtask

  task automatic test_full_load();
    do_reset();
    for (int i = 0; i < 64; i++) begin
      ld_valid = 1; ld_nibble = 4'($urandom); ld_last = 0;
      m_mem[i] = ld_nibble;
      step();
    end
    m_len = 64;
    idle_inputs();
    $display("full load prog_len=%0d ld_ready=%0b", prog_len, ld_ready);
    if (prog_len !== 7'd64 || ld_ready !== 1'b0 || busy_load !== 1'b0) begin
      errors++; $display("FAIL full_load got=%0d/%b/%b want=64/0/0", prog_len, ld_ready, busy_load);
    end
    checks++;
    do_fetch(6'd63);
    for (int k = 0; k < 12; k++) do_fetch(6'($urandom));
  endtask

  task automatic test_reset_mid_load();
    do_reset();
    for (int i = 0; i < 10; i++) begin
      ld_valid = 1; ld_nibble = 4'($urandom); ld_last = 0;
      m_mem[i] = ld_nibble;
      step();
    end
    idle_inputs();
    rst_n = 0;
    step();
    model_reset();
    $display("mid-load reset ld_ready=%0b prog_len=%0d", ld_ready, prog_len);
    if (ld_ready !== 1'b0 || prog_len !== 7'd0) begin
      errors++; $display("FAIL midrst got=%b/%0d want=0/0", ld_ready, prog_len);
    end
    checks++;
    rst_n = 1;
    step();
    if (ld_ready !== 1'b1) begin errors++; $display("FAIL midrst_ready got=%b want=1", ld_ready); end
    checks++;
    if_req = 1; if_addr = 6'd0; rf_req = 1; rf_addr = 3'd3;
    step();
    idle_inputs();
    $display("load-state requests if_valid=%0b rf_valid=%0b", if_valid, rf_valid);
    if (if_valid !== 1'b0 || rf_valid !== 1'b0) begin
      errors++; $display("FAIL load_ignore got=%b%b want=00", if_valid, rf_valid);
    end
    checks++;
    for (int i = 0; i < 4; i++) begin
      ld_valid = 1; ld_nibble = (i == 0) ? 4'h2 : 4'(i); ld_last = (i == 3);
      m_mem[i] = ld_nibble;
      step();
    end
    m_len = 4;
    idle_inputs();
    if (prog_len !== 7'd4) begin errors++; $display("FAIL short_len got=%0d want=4", prog_len); end
    checks++;
    rf_req = 1; rf_addr = 3'd3;
    step();
    idle_inputs();
    $display("R3 after reset data=%0h", rf_data);
    if (rf_valid !== 1'b1 || rf_data !== m_reg[3]) begin
      errors++; $display("FAIL r3_reinit got=%b/%0h want=1/%0h", rf_valid, rf_data, m_reg[3]);
    end
    checks++;
    do_fetch(6'd0);
    do_fetch(6'd4);
  endtask

  initial begin
    test_reset();
    test_load_program();
    test_fetch();
    test_end();
    test_regfile();
    test_back_to_back();
    test_full_load();
    test_reset_mid_load();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dep_program_server.md
Name: dep_program_server

Overview:
Responder side of the dependency-checker fetch/register interface. It holds a 64x4 instruction-nibble memory and an 8x8 register file, and answers the checker's instruction fetches, register reads and write-backs with a registered 1-cycle latency. A nibble-stream load port fills the program before execution starts. The block tracks the END opcode so that the rest of the system can see when the program is done.

Parameters:
ADDR_W, 6, instruction nibble address width (depth = 2**ADDR_W = 64)
REG_AW, 3, register address width (8 registers)
DATA_W, 8, register data width
REG_INIT_BASE, 2, reset value of R[i] is REG_INIT_BASE + i

Ports:
clk  in  1  clock
rst_n  in  1  reset; synchronous, active-low
ld_valid  in  1  load nibble valid
ld_ready  out  1  block accepts load nibbles
ld_nibble  in  4  program nibble; order per instruction is opcode, dest, src1, src2
ld_last  in  1  final nibble of program
if_req  in  1  instruction fetch request
if_addr  in  ADDR_W  fetch address
if_valid  out  1  fetch response valid
if_data  out  4  fetched nibble
rf_req  in  1  register read request
rf_addr  in  REG_AW  read address
rf_valid  out  1  read response valid
rf_data  out  DATA_W  read data
wb_valid  in  1  write-back strobe
wb_addr  in  REG_AW  write-back address
wb_data  in  DATA_W  write-back data
busy_load  out  1  state == LOAD
end_seen  out  1  END opcode has been fetched
prog_len  out  ADDR_W+1  number of loaded nibbles

Behaviour:
- FSM states: LOAD, SERVE, DONE. Reset (rst_n=0 at a clk edge) forces LOAD.
- Reset values: ld_ready=0, if_valid=0, if_data=0, rf_valid=0, rf_data=0, end_seen=0, prog_len=0, load pointer=0, R[i]=REG_INIT_BASE+i. Instruction memory is not cleared.
- LOAD:
  - ld_ready=1 starting from the first edge after rst_n goes high.
  - On ld_valid&&ld_ready the nibble is written to mem[ptr] and ptr increments.
  - The load ends when ld_last is accepted or when the nibble at ptr=63 is accepted. On the next edge: prog_len=ptr+1, ld_ready=0, state moves to SERVE.
  - if_req, rf_req and wb_valid are ignored in LOAD; the valid outputs stay 0.
- SERVE:
  - if_req at edge N gives if_valid=1 at edge N+1, with if_data=mem[if_addr] when if_addr<prog_len, otherwise 4'h4 (END).
  - When the returned nibble is 4'h4 and if_addr[1:0]==0 (opcode slot), end_seen=1 and the state moves to DONE on the same edge.
  - A value of 4 in a non-opcode slot (register 4) does not trigger DONE.
- DONE: fetches are still answered; every nibble at or beyond prog_len returns END. The register file stays fully operational.
- Register file, in SERVE and DONE:
  - rf_req at edge N gives rf_valid=1, rf_data=R[rf_addr] at N+1.
  - wb_valid writes R[wb_addr]=wb_data at the edge.
  - If rf_req and wb_valid target the same address in the same cycle, rf_data returns wb_data (write-first bypass).
- Response timing: if_req and rf_req in the same cycle are both answered next cycle. Back-to-back requests get one response per cycle; there is no backpressure on responses.
- Reset mid-operation: any state returns to LOAD; in-flight responses are dropped (valids=0); registers reinitialise.

Decomposition:
- Package dep_pkg holds:
  - opcode constants OP_ADD=0, OP_SUB=1, OP_MUL=2, OP_DIV=3, OP_END=4
  - NIBBLES_PER_INSTR=4
  - field slot indices OPC=0, DST=1, SRC1=2, SRC2=3
  - state enum {LOAD, SERVE, DONE}
- Sub-module dep_regfile: 8x8 register file with synchronous init, write port, registered read and write-first bypass.

Test Plan:
- Load the 29-nibble program 0,5,0,1, 2,6,2,5, 1,5,3,6, 3,6,5,4, 2,2,3,4, 1,6,5,4, 2,6,2,1, 4 with ld_last on nibble 28 -> prog_len=29, ld_ready=0, SERVE one cycle later.
- Fetch addr 7 -> next cycle if_valid=1, if_data=5. Fetch addr 15 (src2 = R4, value 4) -> state stays SERVE.
- Fetch addr 28 -> if_data=4, end_seen=1, state DONE. Then fetch addr 40 -> if_data=4.
- rf_req R5 after reset -> rf_data=7. Then wb R5=8'h0A together with rf_req R5 in the same cycle -> rf_data=8'h0A.
- Load 64 nibbles without ld_last -> auto transition to SERVE with prog_len=64.
- Assert rst_n=0 after 10 nibbles loaded -> prog_len=0, ld_ready=0 during reset, then 1, R3 reads 5, and if_req is ignored while in LOAD.
